// File: rtl/asi_poll_scheduler.sv
// asi_poll_scheduler: AS-i master polling sequencer with response timeout, bounded retry and per-slave result pulses.
module asi_poll_scheduler #(
  parameter int NUM_SLAVES   = 31,
  parameter int RESP_TIMEOUT = 1200,
  parameter int GAP_CYCLES   = 216,
  parameter int MAX_RETRY    = 2
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        enable,
  output logic        tx_req,
  output logic [13:0] tx_frame,
  input  logic        tx_done,
  output logic [4:0]  data_addr,
  input  logic [4:0]  data_in,
  input  logic        rx_done,
  input  logic [15:0] rx_code,
  output logic        res_valid,
  output logic [4:0]  res_addr,
  output logic [4:0]  res_data,
  output logic        res_missing,
  output logic        cycle_done,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, SEND, WAIT_TX, WAIT_RX, REPORT, GAP} state_t;
  localparam logic [4:0]  LAST_ADDR = 5'(NUM_SLAVES);
  localparam logic [12:0] TO_LAST   = 13'(RESP_TIMEOUT - 1);
  localparam logic [12:0] GAP_LAST  = 13'(GAP_CYCLES - 1);
  localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);
  state_t      state_q, state_d;
  logic [4:0]  addr_q, addr_d;
  logic [7:0]  retry_q, retry_d;
  logic [12:0] timer_q, timer_d;
  logic [13:0] frame_q, frame_d;
  logic        req_q, req_d;
  logic        rv_q, rv_d;
  logic        miss_q, miss_d;
  logic        cd_q, cd_d;
  logic [4:0]  raddr_q, raddr_d;
  logic [4:0]  rdata_q, rdata_d;
  logic        unused_rx;
  assign unused_rx = ^rx_code[15:5];
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    retry_d = retry_q;
    timer_d = (timer_q == 13'h1fff) ? timer_q : timer_q + 13'd1;
    frame_d = frame_q;
    req_d   = 1'b0;
    rv_d    = 1'b0;
    cd_d    = 1'b0;
    miss_d  = miss_q;
    raddr_d = raddr_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        addr_d  = 5'd1;
        retry_d = 8'd0;
        timer_d = 13'd0;
        state_d = enable ? SEND : IDLE;
      end
      SEND: begin
        frame_d = {2'b00, addr_q, data_in, ^{addr_q, data_in}, 1'b1};
        req_d   = 1'b1;
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (tx_done) begin
          state_d = WAIT_RX;
          timer_d = 13'd0;
        end
      end
      WAIT_RX: begin
        // a response in the deadline cycle still counts as received
        if (rx_done || (timer_q >= TO_LAST && retry_q >= RETRY_MAX)) begin
          state_d = REPORT;
          rv_d    = 1'b1;
          cd_d    = addr_q == LAST_ADDR;
          raddr_d = addr_q;
          miss_d  = !rx_done;
          rdata_d = rx_done ? rx_code[4:0] : 5'd0;
        end else if (timer_q >= TO_LAST) begin
          retry_d = retry_q + 8'd1;
          state_d = GAP;
          timer_d = 13'd1;
        end
      end
      REPORT: begin
        retry_d = 8'd0;
        addr_d  = (addr_q == LAST_ADDR) ? 5'd1 : addr_q + 5'd1;
        state_d = GAP;
        timer_d = 13'd1;
      end
      GAP: begin
        // the REPORT/timeout cycle counts as the first idle cycle of the gap
        if (timer_q >= GAP_LAST) state_d = enable ? SEND : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= 5'd1;
      retry_q <= 8'd0;
      timer_q <= 13'd0;
      frame_q <= 14'h0001;
      req_q   <= 1'b0;
      rv_q    <= 1'b0;
      miss_q  <= 1'b0;
      cd_q    <= 1'b0;
      raddr_q <= 5'd0;
      rdata_q <= 5'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      retry_q <= retry_d;
      timer_q <= timer_d;
      frame_q <= frame_d;
      req_q   <= req_d;
      rv_q    <= rv_d;
      miss_q  <= miss_d;
      cd_q    <= cd_d;
      raddr_q <= raddr_d;
      rdata_q <= rdata_d;
    end
  end
  assign tx_req      = req_q;
  assign tx_frame    = frame_q;
  assign data_addr   = addr_q;
  assign res_valid   = rv_q;
  assign res_addr    = raddr_q;
  assign res_data    = rdata_q;
  assign res_missing = miss_q;
  assign cycle_done  = cd_q;
  assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_asi_poll_scheduler.sv
// tb_asi_poll_scheduler: directed bench with encoder/decoder models and per-scenario checks.
module tb_asi_poll_scheduler;
  localparam int NS = 3, RT = 200, GC = 8, MR = 2;
  logic        clk_in = 1'b0, rst = 1'b0, enable = 1'b0, tx_done = 1'b0, rx_done = 1'b0;
  logic [4:0]  data_in = 5'h0A;
  logic [15:0] rx_code = 16'h0;
  logic        tx_req, res_valid, res_missing, cycle_done, busy;
  logic [13:0] tx_frame;
  logic [4:0]  data_addr, res_addr, res_data;
  int total = 0, bad = 0, cyc = 0;
  int enc = 0, dec = 0, resp_delay = 100, rx_cyc = 0, txreq_total = 0;
  logic [4:0] last_addr = 5'd0, info = 5'h15;
  bit drop [32];
  int req_cnt [32];

  asi_poll_scheduler #(.NUM_SLAVES(NS), .RESP_TIMEOUT(RT), .GAP_CYCLES(GC), .MAX_RETRY(MR)) dut (
    .clk_in(clk_in), .rst(rst), .enable(enable), .tx_req(tx_req), .tx_frame(tx_frame),
    .tx_done(tx_done), .data_addr(data_addr), .data_in(data_in), .rx_done(rx_done),
    .rx_code(rx_code), .res_valid(res_valid), .res_addr(res_addr), .res_data(res_data),
    .res_missing(res_missing), .cycle_done(cycle_done), .busy(busy)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  // encoder finishes 40 cycles after tx_req; decoder answers resp_delay cycles after tx_done
  initial forever begin
    @(negedge clk_in);
    tx_done = 1'b0;
    rx_done = 1'b0;
    if (tx_req) begin
      enc = 40;
      dec = 0;
      last_addr = tx_frame[11:7];
      req_cnt[last_addr]++;
      txreq_total++;
    end else if (enc > 0) begin
      enc--;
      if (enc == 0) begin
        tx_done = 1'b1;
        dec = drop[last_addr] ? 0 : resp_delay;
      end
    end else if (dec > 0) begin
      dec--;
      if (dec == 0) begin
        rx_done = 1'b1;
        rx_code = {11'h5A3, info};
        rx_cyc = cyc;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk_in);
    #1;
  endtask

  task automatic wait_res(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      tick();
      ok = res_valid;
    end
  endtask

  task automatic wait_req(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      tick();
      ok = tx_req;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    enable = 1'b0;
    tick();
    tick();
    total++; if (tx_frame !== 14'h0001) begin bad++; $display("FAIL reset_frame: got %h want 0001", tx_frame); end
    total++; if ({tx_req, res_valid, res_missing, cycle_done, busy, res_addr, res_data} !== 15'd0) begin
      bad++; $display("FAIL reset_outputs: got %b want 0", {tx_req, res_valid, res_missing, cycle_done, busy, res_addr, res_data});
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    int r;
    enable = 1'b1;
    tick();
    total++; if (tx_req !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL basic_send: tx_req=%b busy=%b want 0 1", tx_req, busy); end
    tick();
    total++; if (tx_req !== 1'b1) begin bad++; $display("FAIL basic_req_latency: tx_req=%b want 1", tx_req); end
    total++; if (tx_frame !== 14'h00AB) begin bad++; $display("FAIL basic_frame: got %h want 00ab", tx_frame); end
    total++; if (data_addr !== 5'd1) begin bad++; $display("FAIL basic_data_addr: got %0d want 1", data_addr); end
    wait_res(400, ok);
    total++; if (!ok) begin bad++; $display("FAIL basic_res_timeout: got none want res_valid"); end
    total++; if ({res_addr, res_data, res_missing, cycle_done} !== {5'd1, 5'h15, 1'b0, 1'b0}) begin
      bad++; $display("FAIL basic_result: got addr=%0d data=%h miss=%b cd=%b want 1 15 0 0", res_addr, res_data, res_missing, cycle_done);
    end
    total++; if (cyc - rx_cyc != 1) begin bad++; $display("FAIL basic_rx_latency: got %0d want 1", cyc - rx_cyc); end
    r = cyc;
    wait_req(50, ok);
    total++; if (!ok || cyc - r != GC + 1) begin bad++; $display("FAIL basic_spacing: got %0d want %0d", cyc - r, GC + 1); end
    total++; if (tx_frame[11:7] !== 5'd2) begin bad++; $display("FAIL basic_next_addr: got %0d want 2", tx_frame[11:7]); end
  endtask

  task automatic test_wrap();
    bit ok;
    wait_res(400, ok);
    total++; if (!ok || res_addr !== 5'd2 || cycle_done !== 1'b0) begin
      bad++; $display("FAIL wrap_addr2: got addr=%0d cd=%b want 2 0", res_addr, cycle_done);
    end
    wait_res(400, ok);
    total++; if (!ok || res_addr !== 5'd3 || cycle_done !== 1'b1 || res_data !== 5'h15) begin
      bad++; $display("FAIL wrap_addr3: got addr=%0d cd=%b data=%h want 3 1 15", res_addr, cycle_done, res_data);
    end
    tick();
    total++; if (cycle_done !== 1'b0) begin bad++; $display("FAIL wrap_cd_pulse: got %b want 0", cycle_done); end
    wait_req(50, ok);
    total++; if (!ok || tx_frame[11:7] !== 5'd1) begin bad++; $display("FAIL wrap_next_addr: got %0d want 1", tx_frame[11:7]); end
  endtask

  task automatic test_missing();
    bit ok;
    drop[2] = 1'b1;
    req_cnt[2] = 0;
    wait_res(400, ok);
    total++; if (!ok || res_addr !== 5'd1 || res_missing !== 1'b0) begin
      bad++; $display("FAIL missing_pre: got addr=%0d miss=%b want 1 0", res_addr, res_missing);
    end
    wait_res(2000, ok);
    total++; if (!ok || res_addr !== 5'd2 || res_missing !== 1'b1 || res_data !== 5'd0) begin
      bad++; $display("FAIL missing_result: got addr=%0d miss=%b data=%h want 2 1 0", res_addr, res_missing, res_data);
    end
    total++; if (req_cnt[2] != MR + 1) begin bad++; $display("FAIL missing_tries: got %0d want %0d", req_cnt[2], MR + 1); end
    drop[2] = 1'b0;
    wait_res(400, ok);
    total++; if (!ok || res_addr !== 5'd3 || res_missing !== 1'b0) begin
      bad++; $display("FAIL missing_next: got addr=%0d miss=%b want 3 0", res_addr, res_missing);
    end
  endtask

  task automatic test_race();
    bit ok;
    resp_delay = RT;
    info = 5'h0C;
    req_cnt[1] = 0;
    wait_res(600, ok);
    total++; if (!ok || res_addr !== 5'd1 || res_missing !== 1'b0 || res_data !== 5'h0C) begin
      bad++; $display("FAIL race_result: got addr=%0d miss=%b data=%h want 1 0 0c", res_addr, res_missing, res_data);
    end
    total++; if (req_cnt[1] != 1) begin bad++; $display("FAIL race_retry: got %0d tries want 1", req_cnt[1]); end
    resp_delay = 100;
    info = 5'h15;
  endtask

  task automatic test_enable_drop();
    bit ok;
    int n;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      ok = tx_done;
    end
    total++; if (!ok) begin bad++; $display("FAIL drop_tx_done: got none want tx_done"); end
    tick();
    enable = 1'b0;
    wait_res(400, ok);
    total++; if (!ok || res_addr !== 5'd2 || res_missing !== 1'b0) begin
      bad++; $display("FAIL drop_result: got addr=%0d miss=%b want 2 0", res_addr, res_missing);
    end
    n = txreq_total;
    for (int i = 0; i < GC - 1; i++) tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL drop_busy_gap: got %b want 1", busy); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_busy_idle: got %b want 0", busy); end
    for (int i = 0; i < 30; i++) tick();
    total++; if (txreq_total != n || busy !== 1'b0) begin
      bad++; $display("FAIL drop_no_req: got %0d extra busy=%b want 0 0", txreq_total - n, busy);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int r;
    enable = 1'b1;
    wait_res(400, ok);
    wait_req(50, ok);
    total++; if (!ok || tx_frame[11:7] !== 5'd2) begin bad++; $display("FAIL rstmid_pre: got %0d want 2", tx_frame[11:7]); end
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b0;
    #1;
    total++; if (tx_frame !== 14'h0001 || busy !== 1'b0 || res_addr !== 5'd0 || res_data !== 5'd0) begin
      bad++; $display("FAIL rstmid_clear: got frame=%h busy=%b addr=%0d data=%h want 0001 0 0 0", tx_frame, busy, res_addr, res_data);
    end
    tick();
    rst = 1'b1;
    r = cyc;
    wait_req(20, ok);
    total++; if (!ok || cyc - r != 2) begin bad++; $display("FAIL rstmid_latency: got %0d want 2", cyc - r); end
    total++; if (tx_frame !== 14'h00AB) begin bad++; $display("FAIL rstmid_frame: got %h want 00ab", tx_frame); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_missing();
    test_race();
    test_enable_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
